// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_t;

   localparam int unsigned UART_CLK_DIV_DEFAULT = 32'd868;

endpackage

// File: rtl/sync_2ff_edge.sv
// Two-flop synchronizer for the serial line plus a history flop for falling-edge detection.
module sync_2ff_edge (
   input  logic clk,
   input  logic reset,
   input  logic rx,
   output logic rx_sync,
   output logic fall_edge
);

   logic meta;
   logic sync_ff;
   logic prev;

   // Flops preset to the idle-high level so reset never fabricates an edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         meta    <= 1'b1;
         sync_ff <= 1'b1;
         prev    <= 1'b1;
      end else begin
         meta    <= rx;
         sync_ff <= meta;
         prev    <= sync_ff;
      end
   end

   assign rx_sync   = sync_ff;
   assign fall_edge = prev & ~sync_ff;

endmodule

// File: rtl/uart_rx_module.sv
// 8N1 UART receiver with valid/ready output holding register, framing and overrun pulses.
module uart_rx_module
   import uart_pkg::*;
#(
   parameter int unsigned CLK_DIV = UART_CLK_DIV_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] data_out,
   output logic       data_valid,
   input  logic       data_ready,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam logic [15:0] CNT_FULL = 16'(CLK_DIV - 32'd1);
   localparam logic [15:0] CNT_HALF = 16'(CLK_DIV / 32'd2 - 32'd1);

   logic        rx_sync;
   logic        fall_edge;

   rx_state_t   state, state_nxt;
   logic [15:0] clk_cnt, clk_cnt_nxt;
   logic [2:0]  bit_cnt, bit_cnt_nxt;
   logic [7:0]  shift, shift_nxt;
   logic [7:0]  data_out_nxt;
   logic        data_valid_nxt;
   logic        frame_err_nxt;
   logic        overrun_nxt;
   logic        busy_nxt;
   logic        deliver;

   sync_2ff_edge u_sync (
      .clk       (clk),
      .reset     (reset),
      .rx        (rx),
      .rx_sync   (rx_sync),
      .fall_edge (fall_edge)
   );

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         clk_cnt    <= 16'd0;
         bit_cnt    <= 3'd0;
         shift      <= 8'd0;
         data_out   <= 8'd0;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_nxt;
         clk_cnt    <= clk_cnt_nxt;
         bit_cnt    <= bit_cnt_nxt;
         shift      <= shift_nxt;
         data_out   <= data_out_nxt;
         data_valid <= data_valid_nxt;
         frame_err  <= frame_err_nxt;
         overrun    <= overrun_nxt;
         busy       <= busy_nxt;
      end
   end

   // Next-state, bit sampling and delivery handshake.
   always_comb begin
      state_nxt      = state;
      clk_cnt_nxt    = clk_cnt;
      bit_cnt_nxt    = bit_cnt;
      shift_nxt      = shift;
      data_out_nxt   = data_out;
      data_valid_nxt = data_valid;
      frame_err_nxt  = 1'b0;
      overrun_nxt    = 1'b0;
      deliver        = 1'b0;

      case (state)
         IDLE: begin
            if (fall_edge) begin
               state_nxt   = START;
               clk_cnt_nxt = CNT_HALF;
            end else begin
               state_nxt   = IDLE;
            end
         end
         START: begin
            if (clk_cnt != 16'd0) begin
               clk_cnt_nxt = clk_cnt - 16'd1;
            end else if (!rx_sync) begin
               state_nxt   = DATA;
               clk_cnt_nxt = CNT_FULL;
               bit_cnt_nxt = 3'd0;
            end else begin
               state_nxt   = IDLE;
            end
         end
         DATA: begin
            if (clk_cnt != 16'd0) begin
               clk_cnt_nxt = clk_cnt - 16'd1;
            end else begin
               shift_nxt   = {rx_sync, shift[7:1]};
               clk_cnt_nxt = CNT_FULL;
               if (bit_cnt == 3'd7) begin
                  bit_cnt_nxt = 3'd0;
                  state_nxt   = STOP;
               end else begin
                  bit_cnt_nxt = bit_cnt + 3'd1;
               end
            end
         end
         STOP: begin
            if (clk_cnt != 16'd0) begin
               clk_cnt_nxt = clk_cnt - 16'd1;
            end else begin
               state_nxt = IDLE;
               if (rx_sync) begin
                  deliver = 1'b1;
               end else begin
                  frame_err_nxt = 1'b1;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      // A consume in the delivery cycle frees the holding register for the new byte.
      if (deliver) begin
         if (!data_valid || data_ready) begin
            data_out_nxt   = shift;
            data_valid_nxt = 1'b1;
         end else begin
            overrun_nxt    = 1'b1;
         end
      end else if (data_valid && data_ready) begin
         data_valid_nxt = 1'b0;
      end else begin
         data_valid_nxt = data_valid;
      end

      busy_nxt = (state_nxt != IDLE);
   end

endmodule

// File: tb/tb_uart_rx_module.sv
// Directed self-checking bench for uart_rx_module at CLK_DIV=16 (10-unit clock, 160-unit bit).
module tb_uart_rx_module;

   localparam int CLK_DIV = 16;
   localparam int BIT_NOM = 160;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx = 1'b1;
   logic       data_ready = 1'b0;
   logic [7:0] data_out;
   logic       data_valid;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int total = 0;
   int bad = 0;
   int ferr_cnt = 0;
   int ovr_cnt = 0;
   int both_cnt = 0;
   int busy_cnt = 0;
   logic [7:0] acc_q[$];

   logic [7:0] baud_data [4] = '{8'h00, 8'hFF, 8'h00, 8'hFF};
   int         baud_bit  [4] = '{155, 165, 165, 155};

   uart_rx_module #(.CLK_DIV(CLK_DIV)) dut (
      .clk        (clk),
      .reset      (reset),
      .rx         (rx),
      .data_out   (data_out),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
      if (frame_err && overrun) both_cnt++;
      if (busy) busy_cnt++;
      if (data_valid && data_ready) acc_q.push_back(data_out);
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_ready(input logic v);
      @(posedge clk);
      #1 data_ready = v;
   endtask

   task automatic consume();
      set_ready(1'b1);
      set_ready(1'b0);
   endtask

   task automatic clear_mon();
      ferr_cnt = 0;
      ovr_cnt  = 0;
      busy_cnt = 0;
      acc_q.delete();
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_val, input int bit_t);
      @(negedge clk);
      rx = 1'b0;
      #(bit_t);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         #(bit_t);
      end
      rx = stop_val;
      #(bit_t);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      wait_cyc(3);
      check_val("rst_data_out", 32'(data_out), 32'h00);
      check_val("rst_valid", 32'(data_valid), 32'h0);
      check_val("rst_busy", 32'(busy), 32'h0);
      check_val("rst_ferr", 32'(frame_err), 32'h0);
      check_val("rst_ovr", 32'(overrun), 32'h0);
      reset = 1'b0;
      wait_cyc(5);

      // Single byte held until consumed.
      clear_mon();
      send_frame(8'hA5, 1'b1, BIT_NOM);
      wait_cyc(2);
      check_val("a5_data", 32'(data_out), 32'hA5);
      check_val("a5_valid", 32'(data_valid), 32'h1);
      wait_cyc(30);
      check_val("a5_valid_held", 32'(data_valid), 32'h1);
      consume();
      @(negedge clk);
      check_val("a5_valid_clr", 32'(data_valid), 32'h0);
      check_val("a5_data_keep", 32'(data_out), 32'hA5);
      check_val("a5_no_ovr", 32'(ovr_cnt), 32'd0);

      // Back-to-back with no consumer: second byte dropped.
      clear_mon();
      send_frame(8'h3C, 1'b1, BIT_NOM);
      send_frame(8'hC3, 1'b1, BIT_NOM);
      wait_cyc(2);
      check_val("ovr_cnt", 32'(ovr_cnt), 32'd1);
      check_val("ovr_data", 32'(data_out), 32'h3C);
      check_val("ovr_valid", 32'(data_valid), 32'h1);
      check_val("ovr_no_ferr", 32'(ferr_cnt), 32'd0);
      consume();
      wait_cyc(2);

      // Same pair with data_ready tied high.
      set_ready(1'b1);
      clear_mon();
      send_frame(8'h3C, 1'b1, BIT_NOM);
      send_frame(8'hC3, 1'b1, BIT_NOM);
      wait_cyc(4);
      check_val("rdy_count", 32'(acc_q.size()), 32'd2);
      if (acc_q.size() == 2) begin
         check_val("rdy_byte0", 32'(acc_q[0]), 32'h3C);
         check_val("rdy_byte1", 32'(acc_q[1]), 32'hC3);
      end
      check_val("rdy_no_ovr", 32'(ovr_cnt), 32'd0);
      check_val("rdy_valid", 32'(data_valid), 32'h0);
      set_ready(1'b0);

      // Framing error, then line stuck low.
      clear_mon();
      send_frame(8'h55, 1'b0, BIT_NOM);
      wait_cyc(1);
      check_val("ferr_cnt", 32'(ferr_cnt), 32'd1);
      check_val("ferr_valid", 32'(data_valid), 32'h0);
      check_val("ferr_no_ovr", 32'(ovr_cnt), 32'd0);
      check_val("ferr_data_keep", 32'(data_out), 32'hC3);
      busy_cnt = 0;
      wait_cyc(60);
      check_val("low_no_start", 32'(busy_cnt), 32'd0);
      rx = 1'b1;
      wait_cyc(20);
      send_frame(8'h5A, 1'b1, BIT_NOM);
      wait_cyc(2);
      check_val("after_low_data", 32'(data_out), 32'h5A);
      check_val("after_low_valid", 32'(data_valid), 32'h1);
      consume();
      wait_cyc(2);

      // Four-cycle low glitch: START holds for CLK_DIV/2 cycles then aborts.
      clear_mon();
      @(negedge clk);
      rx = 1'b0;
      #40;
      rx = 1'b1;
      wait_cyc(20);
      check_val("glitch_busy_cycles", 32'(busy_cnt), 32'd8);
      check_val("glitch_busy", 32'(busy), 32'h0);
      check_val("glitch_valid", 32'(data_valid), 32'h0);
      check_val("glitch_data", 32'(data_out), 32'h5A);
      check_val("glitch_pulses", 32'(ferr_cnt + ovr_cnt), 32'd0);

      // Reset in the middle of bit 4 of 0xFF.
      clear_mon();
      @(negedge clk);
      rx = 1'b0;
      #(BIT_NOM);
      rx = 1'b1;
      #(BIT_NOM * 4 + BIT_NOM / 2);
      check_val("mid_busy", 32'(busy), 32'h1);
      @(posedge clk);
      #1 reset = 1'b1;
      wait_cyc(2);
      check_val("mr_busy", 32'(busy), 32'h0);
      check_val("mr_data", 32'(data_out), 32'h00);
      check_val("mr_valid", 32'(data_valid), 32'h0);
      reset = 1'b0;
      wait_cyc(100);
      check_val("mr_no_deliver", 32'(data_valid), 32'h0);
      send_frame(8'h81, 1'b1, BIT_NOM);
      wait_cyc(2);
      check_val("mr_81_data", 32'(data_out), 32'h81);
      check_val("mr_81_valid", 32'(data_valid), 32'h1);
      consume();
      wait_cyc(2);

      // +/-3% baud offset.
      set_ready(1'b1);
      clear_mon();
      for (int k = 0; k < 4; k++) begin
         send_frame(baud_data[k], 1'b1, baud_bit[k]);
      end
      wait_cyc(4);
      check_val("baud_count", 32'(acc_q.size()), 32'd4);
      if (acc_q.size() == 4) begin
         for (int k = 0; k < 4; k++) begin
            check_val($sformatf("baud_byte%0d", k), 32'(acc_q[k]), 32'(baud_data[k]));
         end
      end
      check_val("baud_no_err", 32'(ferr_cnt + ovr_cnt), 32'd0);
      set_ready(1'b0);

      check_val("never_both", 32'(both_cnt), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
